// File: rtl/uart_tx_flow_ctrl.sv
// UART transmitter with a one-entry holding register and CTS flow control.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high; waits for a held byte and synchronized CTS low
// START  | start bit (line low) for one bit-time
// DATA   | 8 data bits, LSB first, one bit-time each
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (line high); may chain straight into START
module uart_tx_flow_ctrl #(
    parameter int unsigned ClocksPerBaud = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_in_valid,
    output logic       byte_in_ready,
    input  logic       clear_to_send_n_in,
    output logic       tx_out,
    output logic       busy
);

    localparam logic [15:0] BAUD_RELOAD = 16'(ClocksPerBaud - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state;
    logic        cts_meta;
    logic        cts_n_s;
    logic        hold_full;
    logic [7:0]  hold_data;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx;
    logic [15:0] baud_cnt;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    logic baud_done;
    logic accept;
    logic load;
    logic frame_end;
    logic hold_full_nxt;
    logic busy_nxt;
    logic line_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta <= 1'b1;
            cts_n_s  <= 1'b1;
        end else begin
            cts_meta <= clear_to_send_n_in;
            cts_n_s  <= cts_meta;
        end
    end

    // A new frame may start from IDLE or directly at the end of STOP so that
    // back-to-back bytes leave no idle gap on the line.
    always_comb begin
        baud_done     = (baud_cnt == 16'd0);
        accept        = byte_in_valid & byte_in_ready;
        load          = hold_full & ~cts_n_s &
                        ((state == IDLE) | ((state == STOP) & baud_done));
        frame_end     = (state == STOP) & baud_done & ~load;
        hold_full_nxt = accept | (hold_full & ~load);
        busy_nxt      = hold_full_nxt | load | ((state != IDLE) & ~frame_end);
    end

    always_comb begin
        line_bit = 1'b1;
        case (state)
            IDLE:    line_bit = 1'b1;
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_bit = parity_bit;
`endif
            STOP:    line_bit = 1'b1;
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx_out        <= 1'b1;
            byte_in_ready <= 1'b1;
            busy          <= 1'b0;
            hold_full     <= 1'b0;
            hold_data     <= 8'h00;
            shift_reg     <= 8'h00;
            bit_idx       <= 3'd0;
            baud_cnt      <= 16'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit    <= 1'b0;
`endif
        end else begin
            // tx_out is the registered image of the current state's line value
            tx_out        <= line_bit;
            byte_in_ready <= ~hold_full_nxt;
            busy          <= busy_nxt;
            hold_full     <= hold_full_nxt;
            if (accept) begin
                hold_data <= byte_in;
            end
            if (load) begin
                state     <= START;
                shift_reg <= hold_data;
                bit_idx   <= 3'd0;
                baud_cnt  <= BAUD_RELOAD;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^hold_data;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        baud_cnt <= 16'd0;
                    end
                    START: begin
                        if (baud_done) begin
                            state    <= DATA;
                            baud_cnt <= BAUD_RELOAD;
                        end else begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end
                    end
                    DATA: begin
                        if (baud_done) begin
                            baud_cnt  <= BAUD_RELOAD;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (baud_done) begin
                            state    <= STOP;
                            baud_cnt <= BAUD_RELOAD;
                        end else begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end
                    end
`endif
                    STOP: begin
                        if (baud_done) begin
                            state <= IDLE;
                        end else begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        baud_cnt <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_flow_ctrl.sv
// Self-checking bench for uart_tx_flow_ctrl: a line monitor decodes frames
// and compares them with bytes queued at capture time.
module tb_uart_tx_flow_ctrl;

    localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int FL = FBITS * CPB;

    logic       clk;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_in_valid;
    logic       byte_in_ready;
    logic       clear_to_send_n_in;
    logic       tx_out;
    logic       busy;

    int         n_cmp;
    int         n_bad;
    int         cyc;
    int         frames_seen;
    int         last_start;
    logic [7:0] exp_q[$];

    uart_tx_flow_ctrl #(.ClocksPerBaud(CPB)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .byte_in            (byte_in),
        .byte_in_valid      (byte_in_valid),
        .byte_in_ready      (byte_in_ready),
        .clear_to_send_n_in (clear_to_send_n_in),
        .tx_out             (tx_out),
        .busy               (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic mon_sample(output logic v, inout bit ab);
        @(negedge clk);
        v = tx_out;
        if (rst_n !== 1'b1) ab = 1'b1;
    endtask

    task automatic monitor_frames();
        logic       v;
        logic       v0;
        logic [7:0] got;
        logic [7:0] e;
        bit         ab;
        bit         shape_ok;
        int         st;
`ifdef UART_TX_PARITY_EN
        logic       p0;
`endif
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_out === 1'b0) begin
                st       = cyc;
                ab       = 1'b0;
                shape_ok = 1'b1;
                got      = 8'h00;
                for (int i = 1; i < CPB; i++) begin
                    mon_sample(v, ab);
                    if (v !== 1'b0) shape_ok = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    mon_sample(v0, ab);
                    got[b] = v0;
                    for (int i = 1; i < CPB; i++) begin
                        mon_sample(v, ab);
                        if (v !== v0) shape_ok = 1'b0;
                    end
                end
`ifdef UART_TX_PARITY_EN
                mon_sample(p0, ab);
                for (int i = 1; i < CPB; i++) begin
                    mon_sample(v, ab);
                    if (v !== p0) shape_ok = 1'b0;
                end
`endif
                for (int i = 0; i < CPB; i++) begin
                    mon_sample(v, ab);
                    if (v !== 1'b1) shape_ok = 1'b0;
                end
                if (!ab) begin
                    n_cmp++;
                    if (shape_ok !== 1'b1) begin
                        n_bad++;
                        $display("FAIL frame_shape: frame at cycle %0d has a bit not held exactly %0d cycles or bad start/stop, required clean frame", st, CPB);
                    end
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_frame: got byte %h at cycle %0d, required no frame", got, st);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_bad++;
                            $display("FAIL frame_byte: got %h, required %h", got, e);
                        end
`ifdef UART_TX_PARITY_EN
                        n_cmp++;
                        if (p0 !== ^e) begin
                            n_bad++;
                            $display("FAIL parity_bit: got %b for byte %h, required %b", p0, e, ^e);
                        end
`endif
                    end
                    last_start = st;
                    frames_seen++;
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int cap);
        int t;
        t = 0;
        @(negedge clk);
        while (byte_in_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: byte_in_ready=%b after %0d cycles, required 1", byte_in_ready, t);
            cap = cyc;
        end else begin
            byte_in       = b;
            byte_in_valid = 1'b1;
            @(posedge clk);
            #1;
            byte_in_valid = 1'b0;
            exp_q.push_back(b);
            @(negedge clk);
            cap = cyc;
        end
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (frames_seen < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (frames_seen < n) begin
            n_bad++;
            $display("FAIL %s: frames seen %0d, required %0d within %0d cycles", name, frames_seen, n, budget);
        end
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        byte_in            = 8'h00;
        byte_in_valid      = 1'b0;
        clear_to_send_n_in = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx_out !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b, required 1", tx_out); end
        n_cmp++;
        if (byte_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b, required 1", byte_in_ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int c;
        int f0;
        f0 = frames_seen;
        send_byte(8'h55, c);
        wait_frames(f0 + 1, FL + 50, "single_frame_done");
        n_cmp++;
        if (last_start - c !== 2) begin
            n_bad++;
            $display("FAIL start_latency: got %0d cycles, required 2", last_start - c);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_frame: got %b, required 0", busy); end
        n_cmp++;
        if (tx_out !== 1'b1) begin n_bad++; $display("FAIL idle_after_frame: got %b, required 1", tx_out); end
    endtask

    task automatic test_back_to_back();
        int c1;
        int c2;
        int f0;
        int t;
        f0 = frames_seen;
        send_byte(8'h56, c1);
        repeat (20) @(negedge clk);
        send_byte(8'hA9, c2);
        n_cmp++;
        if (byte_in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_after_capture: got %b, required 0", byte_in_ready); end
        t = 0;
        while (byte_in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (cyc !== c1 + 1 + FL) begin
            n_bad++;
            $display("FAIL b2b_ready_release: ready rose at cycle %0d, required %0d", cyc, c1 + 1 + FL);
        end
        wait_frames(f0 + 2, 2 * FL + 50, "b2b_frames_done");
        n_cmp++;
        if (last_start !== c1 + 2 + FL) begin
            n_bad++;
            $display("FAIL b2b_gap: second start at cycle %0d, required %0d", last_start, c1 + 2 + FL);
        end
    endtask

    task automatic test_cts_hold();
        int c;
        int f0;
        int bad_tx;
        int bad_rdy;
        int bad_busy;
        int t0;
        int t;
        f0 = frames_seen;
        @(negedge clk);
        clear_to_send_n_in = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'h12, c);
        bad_tx = 0; bad_rdy = 0; bad_busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) bad_tx++;
            if (byte_in_ready !== 1'b0) bad_rdy++;
            if (busy !== 1'b1) bad_busy++;
        end
        n_cmp++;
        if (bad_tx !== 0) begin n_bad++; $display("FAIL cts_hold_tx: tx_out low in %0d cycles, required 0", bad_tx); end
        n_cmp++;
        if (bad_rdy !== 0) begin n_bad++; $display("FAIL cts_hold_ready: ready high in %0d cycles, required 0", bad_rdy); end
        n_cmp++;
        if (bad_busy !== 0) begin n_bad++; $display("FAIL cts_hold_busy: busy low in %0d cycles, required 0", bad_busy); end
        clear_to_send_n_in = 1'b0;
        t0 = cyc;
        t = 0;
        while (tx_out !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (cyc - t0 !== 4) begin
            n_bad++;
            $display("FAIL cts_release_latency: start bit %0d edges after cts drop, required 4", cyc - t0);
        end
        wait_frames(f0 + 1, FL + 50, "cts_hold_frame_done");
    endtask

    task automatic test_cts_mid_frame();
        int c;
        int c2;
        int f0;
        int bad_tx;
        f0 = frames_seen;
        send_byte(8'hF0, c);
        repeat (30) @(negedge clk);
        clear_to_send_n_in = 1'b1;
        send_byte(8'h81, c2);
        wait_frames(f0 + 1, FL + 50, "cts_mid_frame_done");
        n_cmp++;
        if (last_start !== c + 2) begin
            n_bad++;
            $display("FAIL cts_mid_start: frame started at %0d, required %0d", last_start, c + 2);
        end
        bad_tx = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) bad_tx++;
        end
        n_cmp++;
        if (bad_tx !== 0) begin n_bad++; $display("FAIL cts_mid_wait_tx: tx_out low in %0d cycles, required 0", bad_tx); end
        n_cmp++;
        if (byte_in_ready !== 1'b0) begin n_bad++; $display("FAIL cts_mid_wait_ready: got %b, required 0", byte_in_ready); end
        n_cmp++;
        if (frames_seen !== f0 + 1) begin n_bad++; $display("FAIL cts_mid_wait_frames: got %0d, required %0d", frames_seen, f0 + 1); end
        clear_to_send_n_in = 1'b0;
        wait_frames(f0 + 2, FL + 50, "cts_mid_second_frame");
    endtask

    task automatic test_reset_mid_frame();
        int c;
        int c2;
        int f0;
        int t;
        int bad_tx;
        f0 = frames_seen;
        send_byte(8'h3C, c);
        send_byte(8'h77, c2);
        t = 0;
        while (cyc < c + 2 + 4 * CPB + 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL pre_reset_busy: got %b, required 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx_out !== 1'b1) begin n_bad++; $display("FAIL async_reset_tx: got %b, required 1", tx_out); end
        n_cmp++;
        if (byte_in_ready !== 1'b1) begin n_bad++; $display("FAIL async_reset_ready: got %b, required 1", byte_in_ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %b, required 0", busy); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad_tx = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) bad_tx++;
        end
        n_cmp++;
        if (bad_tx !== 0) begin n_bad++; $display("FAIL post_reset_line: tx_out low in %0d cycles, required 0", bad_tx); end
        n_cmp++;
        if (frames_seen !== f0) begin n_bad++; $display("FAIL post_reset_frames: got %0d, required %0d", frames_seen, f0); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int c1;
        int c2;
        int f0;
        f0 = frames_seen;
        send_byte(8'h56, c1);
        send_byte(8'h57, c2);
        wait_frames(f0 + 2, 2 * FL + 50, "parity_frames_done");
        n_cmp++;
        if (last_start !== c1 + 2 + FL) begin
            n_bad++;
            $display("FAIL parity_frame_length: second start at %0d, required %0d", last_start, c1 + 2 + FL);
        end
    endtask
`endif

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        frames_seen = 0;
        last_start  = 0;
        fork
            monitor_frames();
        join_none
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_cts_hold();
        test_cts_mid_frame();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (10) @(negedge clk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL leftover_expected: %0d bytes never transmitted, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
